endat22_master: RTL and testbench
=================================

Name: endat22_master

Overview:
- Parametrised EnDat 2.2 master receiver that supersedes the fixed 19-bit reader.
- Driven by an explicit request. Sends a run-time mode command, then waits for the encoder start bit with a timeout.
- Captures the F1 alarm bit, a POS_BITS-wide position and a 5-bit CRC, and checks that CRC in hardware.
- Sits between the line transceiver (cken/enc_wr/enc_tdata/enc_data) and the motor-control position consumer.

Parameters:
- POS_BITS, 25: number of position bits received, LSB first (legal range 8..40).
- SETUP_CYC, 2: enc_clk cycles with cken=1 before the mode command starts (legal range 1..15).
- TURN_CYC, 2: cycles between the last mode bit and start-bit search (legal range 1..15).
- TIMEOUT_CYC, 64: maximum cycles spent waiting for the start bit.
- RECOV_CYC, 9: cycles with cken=0 after a frame, before IDLE.
- CRC_POLY, 5'b01011: CRC-5 generator polynomial, x^5 term implicit.

Ports:
- enc_clk, input, 1: encoder-domain clock; all logic is clocked on its rising edge.
- rst, input, 1: synchronous reset, active-high.
- start, input, 1: request one position frame; sampled only in IDLE.
- mode_cmd, input, 6: mode command, latched when start is accepted; sent MSB first.
- enc_data, input, 1: serial data from the encoder.
- cken, output, 1: line clock enable toward the encoder.
- enc_wr, output, 1: transceiver direction; 1 = master drives enc_tdata, 0 = receive.
- enc_tdata, output, 1: serial mode-command data.
- busy, output, 1: high from the cycle after start is accepted until the return to IDLE.
- enc_valid, output, 1: one-cycle pulse; enc_pos and enc_alarm are updated and the CRC passed.
- enc_pos, output, POS_BITS: last position with a good CRC.
- enc_alarm, output, 1: F1 bit of the last frame with a good CRC.
- crc_err, output, 1: one-cycle pulse; received CRC does not match the computed CRC.
- timeout, output, 1: one-cycle pulse; no start bit arrived within TIMEOUT_CYC cycles.
- crc, output, 5: last received CRC field, whether it matched or not.

Behaviour:
- Reset (synchronous, rst=1 on a rising edge):
  - Every output goes to 0, enc_pos to 0 and crc to 0.
  - State goes to IDLE and all counters clear.
  - Reset during a frame aborts it; no valid, crc_err or timeout pulse is emitted.
- IDLE: cken=0, enc_wr=0, busy=0. With start=1, latch mode_cmd and go to SETUP; on the next cycle cken=1 and busy=1.
- SETUP: hold cken=1 for SETUP_CYC cycles, then go to MODE.
- MODE: 6 cycles with enc_wr=1; enc_tdata = latched mode_cmd[5] down to [0], one bit per cycle. Then TURN.
- TURN: enc_wr=0, enc_tdata=0 for TURN_CYC cycles, then WAIT_START.
- WAIT_START:
  - Sample enc_data each cycle; the first cycle with enc_data=1 goes to ALARM.
  - If TIMEOUT_CYC cycles pass without a 1, pulse timeout for 1 cycle and go to RECOVERY.
  - A start bit arriving on the final counted cycle is accepted; it does not count as a timeout.
- ALARM: sample F1 for 1 cycle, then POS.
- POS: POS_BITS cycles; bit k (k=0 first) is stored at position index k.
- CRC: 5 cycles; bits are shifted in MSB first.
- CRC computation:
  - Runs over F1 then the position bits, in line order.
  - Register initialised to 5'b00000 at the ALARM cycle.
  - Each bit b does: fb = b ^ reg[4]; reg = {reg[3:0],0} ^ (fb ? CRC_POLY : 0).
- Frame result: on the cycle after the last CRC bit, crc is updated, then:
  - Match: enc_pos and enc_alarm update and enc_valid pulses.
  - Mismatch: enc_pos and enc_alarm hold and crc_err pulses.
  - The same cycle enters RECOVERY with cken=0.
- RECOVERY: cken=0 for RECOV_CYC cycles, then IDLE.
- start is ignored whenever busy=1, including on the cycle busy rises. A request is never queued.
- enc_valid, crc_err and timeout are mutually exclusive; at most one pulses per frame.
- Latency from start accepted to the result pulse: SETUP_CYC+6+TURN_CYC+W+1+POS_BITS+5+1 cycles, where W is the number of WAIT_START cycles, including the start-bit cycle.

Test Plan:
- Defaults; start with mode_cmd=6'b000111; encoder sends start after 3 cycles, F1=0, pos=25'h0ABCDE, correct CRC -> enc_tdata sequence is 0,0,0,1,1,1 with enc_wr=1; enc_valid pulses once; enc_pos=25'h0ABCDE; enc_alarm=0; busy falls 9 cycles after the pulse.
- Same frame with CRC bit 0 flipped -> crc_err pulse only; enc_pos keeps its previous value; crc shows the flipped value.
- enc_data held at 0 after TURN -> timeout pulses exactly 64 cycles after WAIT_START entry; no enc_valid; IDLE after RECOV_CYC.
- POS_BITS=13, F1=1, pos=13'h1FFF -> enc_valid; enc_alarm=1; enc_pos=13'h1FFF; position bits 0 and 12 land in the correct order.
- start pulses at the mid-frame POS state -> ignored; exactly one result pulse for the frame.
- rst=1 during the POS state -> next cycle all outputs are 0 and state is IDLE; a subsequent normal frame decodes correctly.

Source files
------------

// File: rtl/endat22_master_if.sv
// EnDat 2.2 master bundle: request/command side toward the controller, line side toward
// the transceiver, and the decoded frame result.
//   start, mode_cmd      : frame request and 6-bit mode command (master input)
//   enc_data             : serial data from the encoder (master input)
//   cken/enc_wr/enc_tdata: line clock enable, direction, command data (master output)
//   busy                 : frame in progress (master output)
//   enc_valid/crc_err/timeout : one-cycle frame result pulses (master output)
//   enc_pos/enc_alarm/crc: last good position, its F1 bit, last received CRC (master output)
interface endat22_master_if #(
  parameter int unsigned POS_BITS = 25
);
  logic                start;
  logic [5:0]          mode_cmd;
  logic                enc_data;
  logic                cken;
  logic                enc_wr;
  logic                enc_tdata;
  logic                busy;
  logic                enc_valid;
  logic [POS_BITS-1:0] enc_pos;
  logic                enc_alarm;
  logic                crc_err;
  logic                timeout;
  logic [4:0]          crc;

  modport master (
    input  start, mode_cmd, enc_data,
    output cken, enc_wr, enc_tdata, busy, enc_valid, enc_pos, enc_alarm, crc_err, timeout, crc
  );

  modport slave (
    output start, mode_cmd, enc_data,
    input  cken, enc_wr, enc_tdata, busy, enc_valid, enc_pos, enc_alarm, crc_err, timeout, crc
  );
endinterface

// File: rtl/endat22_master.sv
// EnDat 2.2 master receiver. On request it sends a 6-bit mode command, waits (bounded) for
// the encoder start bit, then captures F1, POS_BITS position bits (LSB first) and a 5-bit
// CRC (MSB first), checking the CRC over F1 and the position bits.
// Ports:
//   i_enc_clk : encoder-domain clock, rising edge
//   i_rst     : synchronous active-high reset
//   bus       : endat22_master_if master modport (request, line and result signals)
module endat22_master #(
  parameter int unsigned POS_BITS    = 25,
  parameter int unsigned SETUP_CYC   = 2,
  parameter int unsigned TURN_CYC    = 2,
  parameter int unsigned TIMEOUT_CYC = 64,
  parameter int unsigned RECOV_CYC   = 9,
  parameter logic [4:0]  CRC_POLY    = 5'b01011
) (
  input logic             i_enc_clk,
  input logic             i_rst,
  endat22_master_if.master bus
);

  typedef enum logic [3:0] {
    StIdle, StSetup, StMode, StTurn, StWait, StAlarm, StPos, StCrc, StRecov
  } state_e;

  state_e              r_state, w_state_d;
  logic [15:0]         r_cnt, w_cnt_d;
  logic [5:0]          r_mode, w_mode_d;
  logic [4:0]          r_crc_calc, w_crc_calc_d;
  logic [4:0]          r_crc_rx, w_crc_rx_d;
  logic [POS_BITS-1:0] r_pos_sh, w_pos_sh_d;
  logic                r_f1, w_f1_d;
  logic [POS_BITS-1:0] r_pos, w_pos_d;
  logic                r_alarm, w_alarm_d;
  logic [4:0]          r_crc, w_crc_d;
  logic                r_valid, w_valid_d;
  logic                r_crc_err, w_crc_err_d;
  logic                r_timeout, w_timeout_d;
  logic                w_cken, w_wr, w_tdata;
  logic [4:0]          w_crc_rx_next;

  function automatic logic [4:0] crc_step(input logic [4:0] c, input logic b);
    logic fb;
    fb = b ^ c[4];
    return {c[3:0], 1'b0} ^ (fb ? CRC_POLY : 5'd0);
  endfunction

  always_comb begin
    w_state_d     = r_state;
    w_cnt_d       = r_cnt;
    w_mode_d      = r_mode;
    w_crc_calc_d  = r_crc_calc;
    w_crc_rx_d    = r_crc_rx;
    w_pos_sh_d    = r_pos_sh;
    w_f1_d        = r_f1;
    w_pos_d       = r_pos;
    w_alarm_d     = r_alarm;
    w_crc_d       = r_crc;
    w_valid_d     = 1'b0;
    w_crc_err_d   = 1'b0;
    w_timeout_d   = 1'b0;
    w_cken        = 1'b0;
    w_wr          = 1'b0;
    w_tdata       = 1'b0;
    w_crc_rx_next = {r_crc_rx[3:0], bus.enc_data};
    unique case (r_state)
      StIdle: begin
        if (bus.start) begin
          w_mode_d  = bus.mode_cmd;
          w_cnt_d   = '0;
          w_state_d = StSetup;
        end
      end
      StSetup: begin
        w_cken = 1'b1;
        if (r_cnt == 16'(SETUP_CYC - 1)) begin
          w_cnt_d   = '0;
          w_state_d = StMode;
        end else begin
          w_cnt_d = r_cnt + 16'd1;
        end
      end
      StMode: begin
        // Command is shifted out of the MSB so no variable bit select is needed.
        w_cken   = 1'b1;
        w_wr     = 1'b1;
        w_tdata  = r_mode[5];
        w_mode_d = {r_mode[4:0], 1'b0};
        if (r_cnt == 16'd5) begin
          w_cnt_d   = '0;
          w_state_d = StTurn;
        end else begin
          w_cnt_d = r_cnt + 16'd1;
        end
      end
      StTurn: begin
        w_cken = 1'b1;
        if (r_cnt == 16'(TURN_CYC - 1)) begin
          w_cnt_d   = '0;
          w_state_d = StWait;
        end else begin
          w_cnt_d = r_cnt + 16'd1;
        end
      end
      StWait: begin
        // Start bit wins over expiry on the last counted cycle.
        w_cken = 1'b1;
        if (bus.enc_data) begin
          w_cnt_d   = '0;
          w_state_d = StAlarm;
        end else if (r_cnt == 16'(TIMEOUT_CYC - 1)) begin
          w_cnt_d     = '0;
          w_timeout_d = 1'b1;
          w_state_d   = StRecov;
        end else begin
          w_cnt_d = r_cnt + 16'd1;
        end
      end
      StAlarm: begin
        w_cken       = 1'b1;
        w_f1_d       = bus.enc_data;
        w_crc_calc_d = crc_step(5'd0, bus.enc_data);
        w_state_d    = StPos;
      end
      StPos: begin
        // Right shift: after POS_BITS bits the first received bit sits at index 0.
        w_cken       = 1'b1;
        w_pos_sh_d   = {bus.enc_data, r_pos_sh[POS_BITS-1:1]};
        w_crc_calc_d = crc_step(r_crc_calc, bus.enc_data);
        if (r_cnt == 16'(POS_BITS - 1)) begin
          w_cnt_d   = '0;
          w_state_d = StCrc;
        end else begin
          w_cnt_d = r_cnt + 16'd1;
        end
      end
      StCrc: begin
        w_cken     = 1'b1;
        w_crc_rx_d = w_crc_rx_next;
        if (r_cnt == 16'd4) begin
          w_cnt_d   = '0;
          w_crc_d   = w_crc_rx_next;
          w_state_d = StRecov;
          if (w_crc_rx_next == r_crc_calc) begin
            w_pos_d   = r_pos_sh;
            w_alarm_d = r_f1;
            w_valid_d = 1'b1;
          end else begin
            w_crc_err_d = 1'b1;
          end
        end else begin
          w_cnt_d = r_cnt + 16'd1;
        end
      end
      StRecov: begin
        if (r_cnt == 16'(RECOV_CYC - 1)) begin
          w_cnt_d   = '0;
          w_state_d = StIdle;
        end else begin
          w_cnt_d = r_cnt + 16'd1;
        end
      end
      default: w_state_d = StIdle;
    endcase
  end

  always_ff @(posedge i_enc_clk) begin
    if (i_rst) begin
      r_state    <= StIdle;
      r_cnt      <= '0;
      r_mode     <= '0;
      r_crc_calc <= '0;
      r_crc_rx   <= '0;
      r_pos_sh   <= '0;
      r_f1       <= 1'b0;
      r_pos      <= '0;
      r_alarm    <= 1'b0;
      r_crc      <= '0;
      r_valid    <= 1'b0;
      r_crc_err  <= 1'b0;
      r_timeout  <= 1'b0;
    end else begin
      r_state    <= w_state_d;
      r_cnt      <= w_cnt_d;
      r_mode     <= w_mode_d;
      r_crc_calc <= w_crc_calc_d;
      r_crc_rx   <= w_crc_rx_d;
      r_pos_sh   <= w_pos_sh_d;
      r_f1       <= w_f1_d;
      r_pos      <= w_pos_d;
      r_alarm    <= w_alarm_d;
      r_crc      <= w_crc_d;
      r_valid    <= w_valid_d;
      r_crc_err  <= w_crc_err_d;
      r_timeout  <= w_timeout_d;
    end
  end

  assign bus.cken      = w_cken;
  assign bus.enc_wr    = w_wr;
  assign bus.enc_tdata = w_tdata;
  assign bus.busy      = (r_state != StIdle);
  assign bus.enc_valid = r_valid;
  assign bus.enc_pos   = r_pos;
  assign bus.enc_alarm = r_alarm;
  assign bus.crc_err   = r_crc_err;
  assign bus.timeout   = r_timeout;
  assign bus.crc       = r_crc;

endmodule

// File: tb/tb_endat22_master.sv
// Bench for endat22_master: two instances (25- and 13-bit position), an encoder model
// answering from a precomputed line-bit queue, and a cycle-indexed expectation model.
module tb_endat22_master;
  localparam int S  = 2;
  localparam int T  = 2;
  localparam int TO = 64;
  localparam int RC = 9;
  localparam logic [4:0] POLY = 5'b01011;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst25, rst13;
  endat22_master_if #(.POS_BITS(25)) b25 ();
  endat22_master_if #(.POS_BITS(13)) b13 ();

  endat22_master #(.POS_BITS(25)) u_dut25 (.i_enc_clk(clk), .i_rst(rst25), .bus(b25.master));
  endat22_master #(.POS_BITS(13)) u_dut13 (.i_enc_clk(clk), .i_rst(rst13), .bus(b13.master));

  int n_cmp = 0;
  int n_err = 0;
  logic [39:0] exp_pos   [2];
  logic        exp_alarm [2];
  logic [4:0]  exp_crc   [2];

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // CRC as the remainder of M(x)*x^5 divided by x^5+POLY, message = F1 then pos LSB first.
  function automatic logic [4:0] crc_ref(input logic f1, input logic [39:0] pos, input int pb);
    logic       d [0:50];
    logic [5:0] g;
    g = {1'b1, POLY};
    for (int i = 0; i < 51; i++) d[i] = 1'b0;
    d[0] = f1;
    for (int k = 0; k < pb; k++) d[1+k] = pos[k];
    for (int i = 0; i <= pb; i++)
      if (d[i]) for (int j = 0; j < 6; j++) d[i+j] = d[i+j] ^ g[5-j];
    return {d[pb+1], d[pb+2], d[pb+3], d[pb+4], d[pb+5]};
  endfunction

  task automatic drive(input int w, input logic st, input logic [5:0] m, input logic d);
    if (w == 0) begin b25.start = st; b25.mode_cmd = m; b25.enc_data = d; end
    else        begin b13.start = st; b13.mode_cmd = m; b13.enc_data = d; end
  endtask

  function automatic logic [6:0] obs(input int w);
    if (w == 0)
      return {b25.cken, b25.enc_wr, b25.enc_tdata, b25.busy, b25.enc_valid, b25.crc_err,
              b25.timeout};
    return {b13.cken, b13.enc_wr, b13.enc_tdata, b13.busy, b13.enc_valid, b13.crc_err,
            b13.timeout};
  endfunction

  function automatic logic [39:0] obs_pos(input int w);
    return (w == 0) ? 40'(b25.enc_pos) : 40'(b13.enc_pos);
  endfunction

  function automatic logic [5:0] obs_ac(input int w);
    return (w == 0) ? {b25.enc_alarm, b25.crc} : {b13.enc_alarm, b13.crc};
  endfunction

  task automatic set_rst(input int w, input logic v);
    if (w == 0) rst25 = v; else rst13 = v;
  endtask

  task automatic check_result(input int w, input string tag);
    check_val({tag, "_pos"}, 64'(obs_pos(w)), 64'(exp_pos[w]));
    check_val({tag, "_alarm_crc"}, 64'(obs_ac(w)), 64'({exp_alarm[w], exp_crc[w]}));
  endtask

  // delay = W (wait cycles incl. start bit), 0 = no start bit; rst_at < 0 = no reset.
  task automatic run_frame(input int w, input logic [5:0] mode, input int delay, input logic f1,
                           input logic [39:0] pos_in, input logic [4:0] crc_x,
                           input bit mid_start, input int rst_at);
    int          pb, n0, nres, idx;
    bit          to;
    logic [39:0] pos;
    logic [4:0]  crc_tx;
    logic        line [$];
    logic [6:0]  e;
    logic        ex_wr, st, dat;
    pb     = (w == 0) ? 25 : 13;
    pos    = pos_in & ((40'd1 << pb) - 40'd1);
    to     = (delay == 0);
    n0     = S + 6 + T + 1;
    crc_tx = crc_ref(f1, pos, pb) ^ crc_x;
    if (to) begin
      for (int i = 0; i < TO + 16; i++) line.push_back(1'b0);
      nres = n0 + TO;
    end else begin
      for (int i = 0; i < delay - 1; i++) line.push_back(1'b0);
      line.push_back(1'b1);
      line.push_back(f1);
      for (int k = 0; k < pb; k++) line.push_back(pos[k]);
      for (int k = 4; k >= 0; k--) line.push_back(crc_tx[k]);
      nres = n0 + delay + 1 + pb + 5;
    end
    @(negedge clk);
    drive(w, 1'b1, mode, 1'b0);
    for (int n = 1; n <= nres + RC + 2; n++) begin
      @(negedge clk);
      ex_wr = (n > S) && (n <= S + 6);
      e = {(n < nres), ex_wr, ex_wr ? mode[5 - (n - S - 1)] : 1'b0, (n < nres + RC),
           (n == nres) && !to && (crc_x == 5'd0), (n == nres) && !to && (crc_x != 5'd0),
           (n == nres) && to};
      check_val($sformatf("w%0d_cyc%0d", w, n), 64'(obs(w)), 64'(e));
      if (n == nres) begin
        if (!to) exp_crc[w] = crc_tx;
        if (!to && crc_x == 5'd0) begin
          exp_pos[w]   = pos;
          exp_alarm[w] = f1;
        end
        check_result(w, $sformatf("w%0d_res", w));
      end
      if (rst_at >= 0 && !to && n == n0 + delay + 1 + rst_at) begin
        drive(w, 1'b0, mode, 1'b0);
        set_rst(w, 1'b1);
        @(negedge clk);
        set_rst(w, 1'b0);
        exp_pos[w]   = '0;
        exp_alarm[w] = 1'b0;
        exp_crc[w]   = '0;
        check_val($sformatf("w%0d_rst_out", w), 64'(obs(w)), 64'd0);
        check_result(w, $sformatf("w%0d_rst", w));
        @(negedge clk);
        return;
      end
      st  = mid_start && (n == 1 || n == n0 + delay + 3);
      idx = n - n0;
      dat = (idx >= 0 && idx < line.size()) ? line[idx] : 1'b0;
      drive(w, st, mode, dat);
    end
    drive(w, 1'b0, mode, 1'b0);
    check_result(w, $sformatf("w%0d_end", w));
  endtask

  initial begin
    int          w, dl, ra;
    logic [4:0]  cx;
    for (int i = 0; i < 2; i++) begin exp_pos[i] = '0; exp_alarm[i] = 1'b0; exp_crc[i] = '0; end
    drive(0, 1'b0, 6'd0, 1'b0);
    drive(1, 1'b0, 6'd0, 1'b0);
    rst25 = 1'b1;
    rst13 = 1'b1;
    repeat (3) @(negedge clk);
    check_val("rst25_out", 64'(obs(0)), 64'd0);
    check_val("rst13_out", 64'(obs(1)), 64'd0);
    check_result(0, "rst25");
    check_result(1, "rst13");
    rst25 = 1'b0;
    rst13 = 1'b0;

    run_frame(0, 6'b000111, 4, 1'b0, 40'h0ABCDE, 5'd0, 1'b0, -1);
    run_frame(0, 6'b000111, 4, 1'b0, 40'h0ABCDE, 5'd1, 1'b0, -1);
    run_frame(0, 6'b101010, 0, 1'b0, 40'h0, 5'd0, 1'b0, -1);
    run_frame(1, 6'b110001, 3, 1'b1, 40'h1FFF, 5'd0, 1'b0, -1);
    run_frame(1, 6'b010011, 2, 1'b0, 40'h1000, 5'd0, 1'b0, -1);
    run_frame(1, 6'b000001, 1, 1'b1, 40'h0001, 5'd0, 1'b0, -1);
    run_frame(0, 6'b111000, 5, 1'b1, 40'h1234567, 5'd0, 1'b1, -1);
    run_frame(0, 6'b011110, 6, 1'b1, 40'h1555555, 5'd0, 1'b0, 3);
    run_frame(0, 6'b100101, 2, 1'b0, 40'h0F0F0F0, 5'd0, 1'b0, -1);
    run_frame(1, 6'b001100, TO, 1'b0, 40'h0ACE, 5'd0, 1'b0, -1);

    for (int f = 0; f < 24; f++) begin
      w  = int'($urandom_range(0, 1));
      dl = ($urandom_range(0, 5) == 0) ? 0 : int'($urandom_range(1, TO));
      cx = ($urandom_range(0, 2) == 0) ? 5'($urandom_range(1, 31)) : 5'd0;
      ra = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 12)) : -1;
      run_frame(w, 6'($urandom), dl, 1'($urandom), {8'($urandom), 32'($urandom)}, cx,
                1'($urandom), ra);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
